// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory,
// next-PC selection (jump / taken beq / sequential), stall, retired-advance
// counter and a sticky fault raised when the next PC leaves the memory.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 1024,
  parameter int          AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          Branch,
  input  logic          Zero,
  input  logic          Jump,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   Instruction,
  output logic [31:0]   PC,
  output logic [31:0]   PC_plus4,
  output logic [31:0]   instr_count,
  output logic          fault
);

  // Reset PC is always word aligned regardless of the parameter's low bits.
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  logic [31:0] mem [DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        in_range;

  // Sequential successor and the fetched word; a faulted stage issues nops.
  assign pc_plus4 = pc_q + 32'd4;
  assign instr    = fault_q ? 32'h0 : mem[pc_q[AW+1:2]];
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next-PC mux: jump beats a taken branch, which beats PC+4.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // A target is fetchable only if every word-index bit above AW is zero.
  assign in_range = (next_pc[31:AW+2] == '0);

  // Next-state for PC, counter and fault; fault and stall both freeze state.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (!fault_q && !stall) begin
      if (in_range) begin
        pc_d  = next_pc;
        cnt_d = cnt_q + 32'd1;
      end else begin
        fault_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_RST;
      cnt_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Program-load port; writes land regardless of reset, stall or fault, so a
  // write to the current word is seen by fetch only from the next cycle.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  assign Instruction = instr;
  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4;
  assign instr_count = cnt_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected fetch state is queued as each step
// is driven and popped for comparison one cycle later.
module tb_inst_fetch;

  localparam int AW = 10;
  localparam int EW = 98; // {chk_instr, fault, count, instr, pc}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          Branch = 1'b0;
  logic          Zero = 1'b0;
  logic          Jump = 1'b0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic [31:0]   Instruction;
  logic [31:0]   PC;
  logic [31:0]   PC_plus4;
  logic [31:0]   instr_count;
  logic          fault;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  inst_fetch #(.RESET_PC(32'h0), .DEPTH(1024), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .Branch(Branch), .Zero(Zero),
    .Jump(Jump), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .Instruction(Instruction), .PC(PC),
    .PC_plus4(PC_plus4), .instr_count(instr_count), .fault(fault)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one word; the write commits at the next edge.
  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  // Queue the expected post-edge state, clock, then pop and compare.
  task automatic step_exp(input string tag, input logic [31:0] pc, input logic chk_i,
                          input logic [31:0] ins, input logic [31:0] cnt, input logic f);
    logic [EW-1:0] e;
    exp_q.push_back({chk_i, f, cnt, ins, pc});
    tick();
    e = exp_q.pop_front();
    chk32({tag, ".pc"}, PC, e[31:0]);
    chk32({tag, ".pc4"}, PC_plus4, e[31:0] + 32'd4);
    if (e[97]) chk32({tag, ".instr"}, Instruction, e[63:32]);
    chk32({tag, ".count"}, instr_count, e[95:64]);
    chk32({tag, ".fault"}, {31'd0, fault}, {31'd0, e[96]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Program load while held in reset.
    rst = 1'b1;
    load(10'd0, 32'h1111_1111);
    load(10'd1, 32'h2222_2222);
    load(10'd2, 32'h3333_3333);
    load(10'd3, 32'h4444_4444);
    load(10'd4, 32'h1000_0003);
    load(10'd5, 32'h5555_5555);
    load(10'd6, 32'h6666_6666);
    load(10'd7, 32'h7777_7777);
    load(10'd8, 32'hAAAA_0008);
    load(10'd9, 32'h0800_0040);
    load(10'h40, 32'h0800_03FF);
    load(10'h3FF, 32'h0BAD_F00D);
    step_exp("reset", 32'h0, 1'b1, 32'h1111_1111, 32'd0, 1'b0);
    rst = 1'b0;

    // Sequential fetch.
    step_exp("seq1", 32'h4, 1'b1, 32'h2222_2222, 32'd1, 1'b0);
    step_exp("seq2", 32'h8, 1'b1, 32'h3333_3333, 32'd2, 1'b0);

    // Stall at 0x8 for three edges, with Jump asserted to prove it is ignored.
    stall = 1'b1; Jump = 1'b1;
    for (int i = 0; i < 3; i++) step_exp("stall", 32'h8, 1'b1, 32'h3333_3333, 32'd2, 1'b0);
    stall = 1'b0; Jump = 1'b0;
    step_exp("unstall", 32'hC, 1'b1, 32'h4444_4444, 32'd3, 1'b0);
    step_exp("seq4", 32'h10, 1'b1, 32'h1000_0003, 32'd4, 1'b0);

    // Taken branch: 0x14 + 3*4.
    Branch = 1'b1; Zero = 1'b1;
    step_exp("br_taken", 32'h20, 1'b1, 32'hAAAA_0008, 32'd5, 1'b0);
    Branch = 1'b0; Zero = 1'b0;

    // Not-taken branch from 0x10.
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    chk32("at_0x10", PC, 32'h10);
    Branch = 1'b1; Zero = 1'b0;
    step_exp("br_not", 32'h14, 1'b1, 32'h5555_5555, 32'd5, 1'b0);
    Branch = 1'b0;

    // Branch to itself (imm = -1) still counts as an advance.
    rst = 1'b1;
    load(10'd4, 32'h1000_FFFF);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Branch = 1'b1; Zero = 1'b1;
    step_exp("br_self", 32'h10, 1'b1, 32'h1000_FFFF, 32'd5, 1'b0);
    step_exp("br_self2", 32'h10, 1'b1, 32'h1000_FFFF, 32'd6, 1'b0);
    Branch = 1'b0; Zero = 1'b0;

    // Jump beats a taken branch at 0x24 (branch would go to 0x128).
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    chk32("at_0x24", PC, 32'h24);
    Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
    step_exp("jump_prio", 32'h100, 1'b1, 32'h0800_03FF, 32'd10, 1'b0);
    Branch = 1'b0; Zero = 1'b0;

    // Jump to the last word, then fall off the end.
    step_exp("jump_last", 32'hFFC, 1'b1, 32'h0BAD_F00D, 32'd11, 1'b0);
    Jump = 1'b0;
    step_exp("oor", 32'hFFC, 1'b1, 32'h0, 32'd11, 1'b1);
    step_exp("frozen1", 32'hFFC, 1'b1, 32'h0, 32'd11, 1'b1);
    Jump = 1'b1;
    step_exp("frozen2", 32'hFFC, 1'b1, 32'h0, 32'd11, 1'b1);
    Jump = 1'b0;
    rst = 1'b1;
    step_exp("rst_fault", 32'h0, 1'b1, 32'h1111_1111, 32'd0, 1'b0);
    rst = 1'b0;

    // Write to the word currently being fetched while stalled.
    step_exp("to_0x4", 32'h4, 1'b1, 32'h2222_2222, 32'd1, 1'b0);
    stall = 1'b1;
    imem_we = 1'b1; imem_waddr = 10'd1; imem_wdata = 32'hDEAD_BEEF;
    #1;
    chk32("wr_old", Instruction, 32'h2222_2222);
    step_exp("wr_new", 32'h4, 1'b1, 32'hDEAD_BEEF, 32'd1, 1'b0);
    imem_we = 1'b0;

    // Reset while stalled.
    rst = 1'b1;
    step_exp("rst_stall", 32'h0, 1'b1, 32'h1111_1111, 32'd0, 1'b0);
    rst = 1'b0; stall = 1'b0;
    step_exp("post_rst", 32'h4, 1'b1, 32'hDEAD_BEEF, 32'd1, 1'b0);

    chk32("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage of the single-cycle MIPS datapath. It sits directly upstream of the controller and datapath.
- Holds the PC register and a word-addressed instruction memory, and drives the 32-bit Instruction word each cycle.
- Computes next-PC from the Branch/Jump decisions that come back from the controller and the ALU Zero flag.
- Provides a program-load write port, a stall input, a retired-instruction counter and a sticky out-of-range fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] forced to 0.
DEPTH, 1024, instruction memory size in 32-bit words; power of two, 2..65536.
AW, 10, word-index width = log2(DEPTH).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and counter this cycle
Branch  in  1  beq decoded (from controller)
Zero  in  1  ALU equality result
Jump  in  1  j decoded (from controller)
imem_we  in  1  program-load write enable
imem_waddr  in  AW  word index for load write
imem_wdata  in  32  word to write
Instruction  out  32  current instruction (to controller/datapath)
PC  out  32  current PC
PC_plus4  out  32  PC + 4 (for branch target / link use downstream)
instr_count  out  32  number of PC advances since reset
fault  out  1  sticky: fetch attempted beyond DEPTH

Behaviour:
- Reset (rst=1 at edge) has priority over everything:
  - PC <= {RESET_PC[31:2],2'b00}; instr_count <= 0; fault <= 0.
  - Memory contents are NOT cleared.
- Instruction memory:
  - Read is combinational: Instruction = mem[PC[AW+1:2]] when fault=0; Instruction = 32'h0 (nop) when fault=1.
  - Write is synchronous: mem[imem_waddr] <= imem_wdata when imem_we=1, independent of rst/stall/fault.
  - Write to the word currently addressed by PC: Instruction shows old data this cycle, new data from the next cycle.
- PC_plus4 = PC + 4, combinational, 32-bit wrap.
- Next-PC selection, in priority order:
  - Jump=1: {PC_plus4[31:28], Instruction[25:0], 2'b00}.
  - Branch=1 & Zero=1: PC_plus4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00}; 32-bit modular add.
  - Otherwise: PC_plus4.
  - Jump and Branch both asserted: Jump wins.
- Range check: next-PC is in range iff next_pc[31:2] < DEPTH. Bits above AW+1 must be zero.
- Update at each non-reset edge:
  - fault=1: PC, instr_count frozen; fault stays 1 until rst.
  - stall=1: PC, instr_count hold; fault unchanged; Branch/Jump ignored.
  - Next-PC out of range: PC holds, fault <= 1, instr_count holds.
  - Otherwise: PC <= next-PC, instr_count <= instr_count + 1 (wraps at 2^32).
- A branch back to itself (offset -1) counts as an advance.
- Latency: a new PC is visible one cycle after the edge; Instruction follows combinationally in the same cycle.
- Reset asserted mid-stall or mid-fault: state returns to reset values at that edge.

Test Plan:
- Reset/sequential:
  - Load mem[0..3] = 0x11111111..0x44444444, pulse rst, run 3 cycles with Branch=Jump=stall=0.
  - Required: PC 0x0,0x4,0x8,0xC; Instruction tracks the loaded words; instr_count 0,1,2,3; fault=0.
- Branch:
  - At PC=0x10, mem[4]=0x10000003, Branch=1.
  - Zero=1 -> next PC=0x20.
  - Repeat with Zero=0 -> next PC=0x14.
  - With imm=0xFFFF, Zero=1 -> PC stays 0x10 and instr_count increments.
- Jump priority:
  - At PC=0x24, mem[9]=0x08000040, Jump=1 and Branch=Zero=1.
  - Required: next PC=0x100 (jump wins).
- Stall:
  - stall=1 for 3 cycles at PC=0x8.
  - Required: PC=0x8 and instr_count unchanged throughout; advances to 0xC on the first edge after stall drops.
- Out of range:
  - Jump to target 0x3FF -> PC=0xFFC. Next edge with no branch/jump.
  - Required: PC stays 0xFFC, fault=1, Instruction=0. Further cycles keep PC and instr_count frozen.
  - Then rst -> PC=0, fault=0, count=0.
- Write/read collision:
  - At PC=0x4, imem_we=1, imem_waddr=1, imem_wdata=0xDEADBEEF with stall=1.
  - Required: Instruction shows the old word this cycle and 0xDEADBEEF the next cycle.
